synaptic_accumulator: RTL and testbench



---
 rtl/synaptic_accumulator.sv | 199 +++++++++++++++++++
 tb/tb_synaptic_accumulator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synaptic_accumulator.sv
// Synapse-side accumulator: folds weighted spike events into a saturating per-neuron current
// buffer, then drains and clears the buffer to the neuron stage once per timestep tick.
module synaptic_accumulator #(
  parameter int unsigned NUM_NEURONS     = 64,
  parameter int unsigned NEURON_ID_WIDTH = 6,
  parameter int unsigned WEIGHT_WIDTH    = 8,
  parameter int unsigned ACC_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_spike_valid,
  input  logic [NEURON_ID_WIDTH-1:0]  s_spike_dest_id,
  input  logic [WEIGHT_WIDTH-1:0]     s_spike_weight,
  input  logic                        s_spike_exc_inh,
  output logic                        s_spike_ready,
  input  logic                        timestep_tick,
  output logic                        m_curr_valid,
  output logic [NEURON_ID_WIDTH-1:0]  m_curr_neuron_id,
  output logic signed [ACC_WIDTH-1:0] m_curr_value,
  input  logic                        m_curr_ready,
  input  logic                        clear_stats,
  output logic                        drain_busy,
  output logic [31:0]                 event_count,
  output logic                        sat_flag,
  output logic                        tick_missed
);

  localparam int unsigned IdxW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam bit AllInRange = ((2 ** NEURON_ID_WIDTH) <= NUM_NEURONS);
  localparam logic [NEURON_ID_WIDTH-1:0] LastIdx = NEURON_ID_WIDTH'(NUM_NEURONS - 1);
  localparam logic [ACC_WIDTH-1:0] MaxVal = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] MinVal = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StAccum, StFlush, StDrain} state_e;

  state_e                       state_q;
  logic                         ready_q;
  logic [NEURON_ID_WIDTH-1:0]   drain_idx_q;

  logic                         p_valid_q, p_valid_d;
  logic [NEURON_ID_WIDTH-1:0]   p_id_q, p_id_d;
  logic [WEIGHT_WIDTH-1:0]      p_weight_q, p_weight_d;
  logic                         p_exc_q, p_exc_d;

  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]  acc_d [NUM_NEURONS];

  logic [31:0]                  event_count_q, event_count_d;
  logic                         sat_flag_q, sat_flag_d;
  logic                         tick_missed_q, tick_missed_d;

  logic                         spike_accept;
  logic                         drain_fire;
  logic                         p_in_range;
  logic                         apply_en;
  logic [IdxW-1:0]              p_idx;
  logic [IdxW-1:0]              drain_sel;
  logic signed [ACC_WIDTH-1:0]  acc_rd;
  logic signed [ACC_WIDTH:0]    cur_ext;
  logic signed [ACC_WIDTH:0]    wt_ext;
  logic signed [ACC_WIDTH:0]    sum;
  logic                         overflow;
  logic signed [ACC_WIDTH-1:0]  sat_val;

  assign spike_accept = s_spike_valid & ready_q;
  assign drain_fire   = (state_q == StDrain) & m_curr_ready;

  // Ids beyond the buffer are counted on accept but never touch the array.
  if (AllInRange) begin : gen_all_in_range
    assign p_in_range = 1'b1;
  end else begin : gen_range_check
    assign p_in_range = (32'(p_id_q) < NUM_NEURONS);
  end

  assign p_idx     = p_id_q[IdxW-1:0];
  assign drain_sel = drain_idx_q[IdxW-1:0];
  assign apply_en  = p_valid_q & p_in_range;

  // Saturating add at one extra bit; the array read sees any write from the previous edge.
  always_comb begin
    acc_rd   = acc_q[p_idx];
    cur_ext  = {acc_rd[ACC_WIDTH-1], acc_rd};
    wt_ext   = {{(ACC_WIDTH + 1 - WEIGHT_WIDTH){1'b0}}, p_weight_q};
    sum      = p_exc_q ? (cur_ext + wt_ext) : (cur_ext - wt_ext);
    overflow = (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]);
    if (overflow) begin
      sat_val = sum[ACC_WIDTH] ? MinVal : MaxVal;
    end else begin
      sat_val = sum[ACC_WIDTH-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (apply_en) begin
      acc_d[p_idx] = sat_val;
    end
    if (drain_fire) begin
      acc_d[drain_sel] = '0;
    end
  end

  always_comb begin
    p_valid_d  = spike_accept;
    p_id_d     = p_id_q;
    p_weight_d = p_weight_q;
    p_exc_d    = p_exc_q;
    if (spike_accept) begin
      p_id_d     = s_spike_dest_id;
      p_weight_d = s_spike_weight;
      p_exc_d    = s_spike_exc_inh;
    end
  end

  // Clearing the stats wins over a same-cycle count or flag set.
  always_comb begin
    event_count_d = event_count_q + 32'(spike_accept);
    sat_flag_d    = sat_flag_q | (apply_en & overflow);
    tick_missed_d = tick_missed_q | (timestep_tick & (state_q != StAccum));
    if (clear_stats) begin
      event_count_d = '0;
      sat_flag_d    = 1'b0;
      tick_missed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      ready_q     <= 1'b0;
      drain_idx_q <= '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (timestep_tick) begin
            state_q <= StFlush;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        StFlush: begin
          state_q     <= StDrain;
          drain_idx_q <= '0;
        end
        StDrain: begin
          if (drain_fire) begin
            if (drain_idx_q == LastIdx) begin
              state_q     <= StAccum;
              ready_q     <= 1'b1;
              drain_idx_q <= '0;
            end else begin
              drain_idx_q <= drain_idx_q + NEURON_ID_WIDTH'(1);
            end
          end
        end
        default: begin
          state_q     <= StAccum;
          ready_q     <= 1'b0;
          drain_idx_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid_q     <= 1'b0;
      p_id_q        <= '0;
      p_weight_q    <= '0;
      p_exc_q       <= 1'b0;
      event_count_q <= '0;
      sat_flag_q    <= 1'b0;
      tick_missed_q <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      p_valid_q     <= p_valid_d;
      p_id_q        <= p_id_d;
      p_weight_q    <= p_weight_d;
      p_exc_q       <= p_exc_d;
      event_count_q <= event_count_d;
      sat_flag_q    <= sat_flag_d;
      tick_missed_q <= tick_missed_d;
      acc_q         <= acc_d;
    end
  end

  assign s_spike_ready    = ready_q;
  assign m_curr_valid     = (state_q == StDrain);
  assign m_curr_neuron_id = drain_idx_q;
  assign m_curr_value     = acc_q[drain_sel];
  assign drain_busy       = (state_q != StAccum);
  assign event_count      = event_count_q;
  assign sat_flag         = sat_flag_q;
  assign tick_missed      = tick_missed_q;

endmodule

// File: tb/tb_synaptic_accumulator.sv
// Bench for synaptic_accumulator: directed cases with literal expectations plus randomized
// traffic checked every cycle against an event-level model of the current buffer.
module tb_synaptic_accumulator;

  localparam int N   = 48;
  localparam int IDW = 6;
  localparam int WW  = 8;
  localparam int AW  = 16;
  localparam int MaxV = 2 ** (AW - 1) - 1;
  localparam int MinV = -(2 ** (AW - 1));

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  s_spike_valid = 1'b0;
  logic [IDW-1:0]        s_spike_dest_id = '0;
  logic [WW-1:0]         s_spike_weight = '0;
  logic                  s_spike_exc_inh = 1'b0;
  logic                  s_spike_ready;
  logic                  timestep_tick = 1'b0;
  logic                  m_curr_valid;
  logic [IDW-1:0]        m_curr_neuron_id;
  logic signed [AW-1:0]  m_curr_value;
  logic                  m_curr_ready = 1'b1;
  logic                  clear_stats = 1'b0;
  logic                  drain_busy;
  logic [31:0]           event_count;
  logic                  sat_flag;
  logic                  tick_missed;

  synaptic_accumulator #(
    .NUM_NEURONS    (N),
    .NEURON_ID_WIDTH(IDW),
    .WEIGHT_WIDTH   (WW),
    .ACC_WIDTH      (AW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_spike_valid   (s_spike_valid),
    .s_spike_dest_id (s_spike_dest_id),
    .s_spike_weight  (s_spike_weight),
    .s_spike_exc_inh (s_spike_exc_inh),
    .s_spike_ready   (s_spike_ready),
    .timestep_tick   (timestep_tick),
    .m_curr_valid    (m_curr_valid),
    .m_curr_neuron_id(m_curr_neuron_id),
    .m_curr_value    (m_curr_value),
    .m_curr_ready    (m_curr_ready),
    .clear_stats     (clear_stats),
    .drain_busy      (drain_busy),
    .event_count     (event_count),
    .sat_flag        (sat_flag),
    .tick_missed     (tick_missed)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Event-level model: events land in the buffer at accept time, flags appear one edge later.
  int          macc [N];
  int          mphase = 0;  // 0 accumulating, 1 flushing, 2 draining
  int          midx = 0;
  bit          mready = 1'b0;
  int unsigned mcnt = 0;
  bit          msat = 1'b0;
  bit          msat_pend = 1'b0;
  bit          mmiss = 1'b0;

  task automatic model_reset();
    for (int i = 0; i < N; i++) macc[i] = 0;
    mphase = 0; midx = 0; mready = 1'b0; mcnt = 0;
    msat = 1'b0; msat_pend = 1'b0; mmiss = 1'b0;
  endtask

  task automatic model_step();
    bit ev, fire;
    int v;
    fire = (mphase == 2) && m_curr_ready;
    ev   = s_spike_valid && mready;
    if (clear_stats) msat = 1'b0;
    else if (msat_pend) msat = 1'b1;
    msat_pend = 1'b0;
    if (ev && int'(s_spike_dest_id) < N) begin
      v = macc[s_spike_dest_id] + (s_spike_exc_inh ? int'(s_spike_weight) : -int'(s_spike_weight));
      if (v > MaxV) begin v = MaxV; msat_pend = 1'b1; end
      if (v < MinV) begin v = MinV; msat_pend = 1'b1; end
      macc[s_spike_dest_id] = v;
    end
    mcnt = clear_stats ? 0 : mcnt + (ev ? 1 : 0);
    if (clear_stats) mmiss = 1'b0;
    else if (timestep_tick && mphase != 0) mmiss = 1'b1;
    case (mphase)
      0: if (timestep_tick) mphase = 1;
      1: begin mphase = 2; midx = 0; end
      default: if (fire) begin
        macc[midx] = 0;
        if (midx == N - 1) mphase = 0;
        else midx++;
      end
    endcase
    mready = (mphase == 0);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("ready", s_spike_ready, mready);
      chk("busy", drain_busy, mphase != 0);
      chk("valid", m_curr_valid, mphase == 2);
      if (mphase == 2) begin
        chk("drain_id", m_curr_neuron_id, midx);
        chk("drain_value", m_curr_value, macc[midx]);
      end else if (!rst_n) begin
        chk("rst_id", m_curr_neuron_id, 0);
        chk("rst_value", m_curr_value, 0);
      end
      chk("event_count", event_count, mcnt);
      chk("sat_flag", sat_flag, msat);
      chk("tick_missed", tick_missed, mmiss);
    end
  end

  // Record what each drain delivers so directed cases can pin literal values.
  int cap  [64];
  int seen [64];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && m_curr_valid && m_curr_ready) begin
        cap[m_curr_neuron_id] = int'(m_curr_value);
        seen[m_curr_neuron_id]++;
      end
    end
  end

  task automatic clear_cap();
    for (int i = 0; i < 64; i++) begin cap[i] = 0; seen[i] = 0; end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int id, input int w, input bit exc);
    s_spike_valid = 1'b1; s_spike_dest_id = IDW'(id);
    s_spike_weight = WW'(w); s_spike_exc_inh = exc;
    step();
    s_spike_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (drain_busy && n < 2000) begin step(); n++; end
    chk(name, drain_busy, 0);
  endtask

  task automatic tick_drain(input string name);
    clear_cap();
    m_curr_ready = 1'b1;
    timestep_tick = 1'b1;
    step();
    timestep_tick = 1'b0;
    wait_drain(name);
    step();
  endtask

  function automatic int nonzero_except(input int skip);
    int c = 0;
    for (int i = 0; i < N; i++) if (i != skip && cap[i] != 0) c++;
    return c;
  endfunction

  function automatic int not_seen_once();
    int c = 0;
    for (int i = 0; i < N; i++) if (seen[i] != 1) c++;
    return c;
  endfunction

  initial begin
    int mode;
    clear_cap();
    repeat (3) step();
    chk("t0_ready_in_reset", s_spike_ready, 0);
    chk("t0_count_in_reset", event_count, 0);
    rst_n = 1'b1;
    step();
    chk("t0_ready_after_rst", s_spike_ready, 1);

    // single event into neuron 5
    send(5, 10, 1'b1);
    tick_drain("t1_drain_done");
    chk("t1_val5", cap[5], 10);
    chk("t1_others_zero", nonzero_except(5), 0);
    chk("t1_each_once", not_seen_once(), 0);
    chk("t1_count", event_count, 1);

    // back-to-back events to one neuron
    send(3, 100, 1'b1);
    s_spike_valid = 1'b1; s_spike_dest_id = 3; s_spike_weight = 30; s_spike_exc_inh = 1'b0;
    step();
    s_spike_dest_id = 3; s_spike_weight = 7; s_spike_exc_inh = 1'b1;
    step();
    s_spike_valid = 1'b0;
    tick_drain("t2_drain_done");
    chk("t2_val3", cap[3], 77);
    tick_drain("t2_second_drain_done");
    chk("t2_val3_cleared", cap[3], 0);

    // saturation, then stats clear
    s_spike_valid = 1'b1; s_spike_dest_id = 0; s_spike_weight = 255; s_spike_exc_inh = 1'b1;
    repeat (200) step();
    s_spike_valid = 1'b0;
    step();
    chk("t3_sat_set", sat_flag, 1);
    tick_drain("t3_drain_done");
    chk("t3_val0", cap[0], 32767);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("t3_sat_cleared", sat_flag, 0);
    chk("t3_count_cleared", event_count, 0);

    // out-of-range destination
    send(50, 77, 1'b1);
    step();
    chk("t4_count_oob", event_count, 1);
    tick_drain("t4_drain_done");
    chk("t4_all_zero", nonzero_except(-1), 0);

    // event in the tick cycle, ready window
    clear_cap();
    s_spike_valid = 1'b1; s_spike_dest_id = 47; s_spike_weight = 1; s_spike_exc_inh = 1'b1;
    timestep_tick = 1'b1;
    step();
    s_spike_valid = 1'b0; timestep_tick = 1'b0;
    for (int k = 1; k <= N + 1; k++) begin
      chk("t5_ready_low", s_spike_ready, 0);
      step();
    end
    chk("t5_ready_back", s_spike_ready, 1);
    chk("t5_val47", cap[47], 1);
    chk("t5_each_once", not_seen_once(), 0);

    // stalled drain with a stray tick
    for (int i = 1; i <= 4; i++) send(i, 20 * i, 1'b1);
    clear_cap();
    timestep_tick = 1'b1;
    step();
    timestep_tick = 1'b0;
    for (int k = 0; k < 600 && drain_busy; k++) begin
      m_curr_ready = (k % 3 == 0);
      timestep_tick = (k == 20);
      step();
    end
    timestep_tick = 1'b0;
    m_curr_ready = 1'b1;
    chk("t6_drain_done", drain_busy, 0);
    chk("t6_each_once", not_seen_once(), 0);
    chk("t6_val4", cap[4], 80);
    chk("t6_tick_missed", tick_missed, 1);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;

    // reset in the middle of a drain
    send(2, 9, 1'b1);
    timestep_tick = 1'b1;
    step();
    timestep_tick = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t7_count_after_rst", event_count, 0);
    tick_drain("t7_drain_done");
    chk("t7_all_zero", nonzero_except(-1), 0);
    chk("t7_each_once", not_seen_once(), 0);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      mode = (cyc / 800) % 3;
      s_spike_valid   = $urandom_range(0, 1) == 1;
      s_spike_exc_inh = (mode == 1) ? ($urandom_range(0, 7) != 0) :
                        (mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      s_spike_dest_id = (mode == 0) ? IDW'($urandom_range(0, 63)) : IDW'($urandom_range(0, 1));
      s_spike_weight  = (mode == 0) ? WW'($urandom_range(0, 255)) : WW'($urandom_range(200, 255));
      timestep_tick   = (mode == 0) ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 499) == 0);
      m_curr_ready    = $urandom_range(0, 3) != 0;
      clear_stats     = $urandom_range(0, 199) == 0;
      rst_n           = !(cyc == 2500 || cyc == 2501);
      step();
    end
    s_spike_valid = 1'b0; timestep_tick = 1'b0; clear_stats = 1'b0;
    m_curr_ready = 1'b1; rst_n = 1'b1;
    wait_drain("rand_final_drain");
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
